memory_writeback_cycle: RTL and testbench

- Back end of the pipeline, after execute. Consumes the memory and writeback controls produced in decode: read/write enables, store data, load type, destination register and write-data select.
- Drives a single-port data memory through a req/ready handshake.
- Sign- or zero-extends load data and selects the writeback value.
- Returns the register-file write port (rf_writeback_enable/addr/data) to decode, and asserts stall upstream while a memory access is outstanding.

---
 rtl/memory_writeback_cycle_if.sv | 22 ++
 rtl/memory_writeback_cycle.sv | 204 ++++++++++++++++++++
 tb/tb_memory_writeback_cycle.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/memory_writeback_cycle_if.sv
// Single-port data memory bus: request side is the master, the memory is the slave.
interface memory_writeback_cycle_if #(
  parameter int XLEN = 32
);
  logic            mem_req;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [3:0]      mem_wstrb;
  logic            mem_ready;
  logic [XLEN-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/memory_writeback_cycle.sv
// Memory/writeback back end: runs one data-memory access at a time, extends load
// data and returns a registered register-file write port to decode.
module memory_writeback_cycle #(
  parameter int XLEN          = 32,
  parameter int REGISTER_SIZE = 5,
  parameter int MEM_TIMEOUT   = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [XLEN-1:0]          alu_result,
  input  logic [XLEN-1:0]          pc_plus4,
  input  logic                     rf_write_enable,
  input  logic [REGISTER_SIZE-1:0] rf_write_addr,
  input  logic [1:0]               rf_write_data_sel,
  input  logic                     dm_read_enable,
  input  logic                     dm_write_enable,
  input  logic [XLEN-1:0]          dm_write_data,
  input  logic [2:0]               dm_load_type,
  memory_writeback_cycle_if.master mem,
  output logic                     stall,
  output logic                     rf_writeback_enable,
  output logic [REGISTER_SIZE-1:0] rf_writeback_addr,
  output logic [XLEN-1:0]          rf_writeback_data,
  output logic                     mem_error
);

  localparam int CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t                   state;
  logic [CNT_W-1:0]         cnt;

  logic [XLEN-1:0]          alu_p0;
  logic [XLEN-1:0]          pc4_p0;
  logic [XLEN-1:0]          rdata_p0;
  logic [REGISTER_SIZE-1:0] rd_p0;
  logic                     rfwe_p0;
  logic                     load_p0;
  logic [1:0]               sel_p0;
  logic [2:0]               typ_p0;
  logic                     vld_p0;

  logic                     mem_we_q;
  logic [XLEN-1:0]          mem_addr_q;
  logic [XLEN-1:0]          mem_wdata_q;
  logic [3:0]               mem_wstrb_q;

  logic                     mem_op;
  logic                     is_store;
  logic                     misal;
  logic                     wb_fire;

  // Access size comes from funct3[1:0]: 00 byte, 01 half, anything else a word.
  function automatic logic misaligned(input logic [2:0] typ, input logic [1:0] off);
    case (typ[1:0])
      2'b00:   return 1'b0;
      2'b01:   return off[0];
      default: return off != 2'b00;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] store_lanes(input logic [2:0] typ,
                                                  input logic [XLEN-1:0] data);
    case (typ[1:0])
      2'b00:   return {(XLEN/8){data[7:0]}};
      2'b01:   return {(XLEN/16){data[15:0]}};
      default: return data;
    endcase
  endfunction

  function automatic logic [3:0] store_strb(input logic st, input logic [2:0] typ,
                                            input logic [1:0] off);
    if (!st) return 4'b0000;
    case (typ[1:0])
      2'b00:   return 4'b0001 << off;
      2'b01:   return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] load_extract(input logic [2:0] typ,
                                                   input logic [1:0] off,
                                                   input logic [XLEN-1:0] rdata);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = rdata[{off, 3'b000} +: 8];
    h = rdata[{off[1], 4'b0000} +: 16];
    case (typ)
      3'b000:  return {{(XLEN-8){b[7]}}, b};
      3'b100:  return {{(XLEN-8){1'b0}}, b};
      3'b001:  return {{(XLEN-16){h[15]}}, h};
      3'b101:  return {{(XLEN-16){1'b0}}, h};
      default: return rdata;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] wb_select(input logic [1:0] sel, input logic ld,
                                                input logic [XLEN-1:0] alu,
                                                input logic [XLEN-1:0] pc4,
                                                input logic [XLEN-1:0] ld_val);
    case (sel)
      2'd1:    return ld ? ld_val : '0;
      2'd2:    return pc4;
      default: return alu;
    endcase
  endfunction

  // A simultaneous read and write enable is treated as a read.
  assign mem_op   = dm_read_enable | dm_write_enable;
  assign is_store = dm_write_enable & ~dm_read_enable;
  assign misal    = misaligned(dm_load_type, alu_result[1:0]);
  assign wb_fire  = vld_p0 & rfwe_p0 & (rd_p0 != '0);

  assign stall         = (state == ACCESS);
  assign mem.mem_req   = (state == ACCESS);
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wdata = mem_wdata_q;
  assign mem.mem_wstrb = mem_wstrb_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state               <= IDLE;
      cnt                 <= '0;
      vld_p0              <= 1'b0;
      alu_p0              <= '0;
      pc4_p0              <= '0;
      rdata_p0            <= '0;
      rd_p0               <= '0;
      rfwe_p0             <= 1'b0;
      load_p0             <= 1'b0;
      sel_p0              <= '0;
      typ_p0              <= '0;
      mem_we_q            <= 1'b0;
      mem_addr_q          <= '0;
      mem_wdata_q         <= '0;
      mem_wstrb_q         <= '0;
      mem_error           <= 1'b0;
      rf_writeback_enable <= 1'b0;
      rf_writeback_addr   <= '0;
      rf_writeback_data   <= '0;
    end else begin
      mem_error <= 1'b0;
      vld_p0    <= 1'b0;

      // Stage p1: writeback of whatever the capture stage completed last cycle
      if (wb_fire) begin
        rf_writeback_enable <= 1'b1;
        rf_writeback_addr   <= rd_p0;
        rf_writeback_data   <= wb_select(sel_p0, load_p0, alu_p0, pc4_p0,
                                         load_extract(typ_p0, alu_p0[1:0], rdata_p0));
      end else begin
        rf_writeback_enable <= 1'b0;
        rf_writeback_addr   <= '0;
        rf_writeback_data   <= '0;
      end

      // Stage p0: accept/capture and the memory access itself
      case (state)
        IDLE: begin
          if (in_valid) begin
            alu_p0  <= alu_result;
            pc4_p0  <= pc_plus4;
            rd_p0   <= rf_write_addr;
            rfwe_p0 <= rf_write_enable;
            load_p0 <= dm_read_enable;
            sel_p0  <= rf_write_data_sel;
            typ_p0  <= dm_load_type;
            if (!mem_op) begin
              vld_p0 <= 1'b1;
            end else if (misal) begin
              mem_error <= 1'b1;
            end else begin
              state       <= ACCESS;
              cnt         <= '0;
              mem_we_q    <= is_store;
              mem_addr_q  <= {alu_result[XLEN-1:2], 2'b00};
              mem_wdata_q <= store_lanes(dm_load_type, dm_write_data);
              mem_wstrb_q <= store_strb(is_store, dm_load_type, alu_result[1:0]);
            end
          end
        end
        ACCESS: begin
          // A ready arriving on the final allowed cycle still completes the access.
          if (mem.mem_ready) begin
            state    <= IDLE;
            rdata_p0 <= mem.mem_rdata;
            vld_p0   <= 1'b1;
          end else if (cnt == CNT_LAST) begin
            state     <= IDLE;
            mem_error <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_writeback_cycle.sv
// Randomized scoreboard bench for memory_writeback_cycle with a byte-level reference model.
module tb_memory_writeback_cycle;
  localparam int XLEN = 32;
  localparam int TMO  = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] alu_result = '0;
  logic [31:0] pc_plus4 = '0;
  logic        rf_write_enable = 1'b0;
  logic [4:0]  rf_write_addr = '0;
  logic [1:0]  rf_write_data_sel = '0;
  logic        dm_read_enable = 1'b0;
  logic        dm_write_enable = 1'b0;
  logic [31:0] dm_write_data = '0;
  logic [2:0]  dm_load_type = '0;
  logic        stall;
  logic        rf_writeback_enable;
  logic [4:0]  rf_writeback_addr;
  logic [31:0] rf_writeback_data;
  logic        mem_error;

  memory_writeback_cycle_if #(.XLEN(XLEN)) mem_bus ();

  memory_writeback_cycle #(.XLEN(XLEN), .REGISTER_SIZE(5), .MEM_TIMEOUT(TMO)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .in_valid            (in_valid),
    .alu_result          (alu_result),
    .pc_plus4            (pc_plus4),
    .rf_write_enable     (rf_write_enable),
    .rf_write_addr       (rf_write_addr),
    .rf_write_data_sel   (rf_write_data_sel),
    .dm_read_enable      (dm_read_enable),
    .dm_write_enable     (dm_write_enable),
    .dm_write_data       (dm_write_data),
    .dm_load_type        (dm_load_type),
    .mem                 (mem_bus),
    .stall               (stall),
    .rf_writeback_enable (rf_writeback_enable),
    .rf_writeback_addr   (rf_writeback_addr),
    .rf_writeback_data   (rf_writeback_data),
    .mem_error           (mem_error)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int unsigned cyc; logic [4:0] addr; logic [31:0] data; } wb_t;
  typedef struct { logic [31:0] addr; logic we; logic [31:0] wdata; logic [3:0] strb; } mreq_t;

  wb_t         wbq[$];
  int unsigned errq[$];
  mreq_t       mq[$];
  mreq_t       cur;
  bit          have_cur = 0;
  bit          in_req = 0;
  bit          mon_en = 0;
  int          checks = 0;
  int          failures = 0;
  int          stall_cnt = 0;
  int          req_cnt = 0;
  int          exp_stall = 0;
  logic [2:0]  load_types [8] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd2, 3'd3, 3'd7};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: access width in bytes from funct3, treating unknown codes as words.
  function automatic int unsigned acc_bytes(input logic [2:0] typ);
    case (typ)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      default:    return 4;
    endcase
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] typ, input int unsigned off,
                                           input logic [31:0] word);
    int unsigned nb;
    logic [31:0] v;
    nb = acc_bytes(typ);
    if (nb == 4) return word;
    v = (word >> (8 * off)) & ((32'd1 << (8 * nb)) - 32'd1);
    if ((typ == 3'd0 || typ == 3'd1) && v >= (32'd1 << (8 * nb - 1)))
      v = v - (32'd1 << (8 * nb));
    return v;
  endfunction

  function automatic logic [31:0] exp_wb(input logic [1:0] sel, input bit ld,
                                         input logic [31:0] alu, input logic [31:0] pc4,
                                         input logic [31:0] ldv);
    if (sel == 2'd1) return ld ? ldv : 32'd0;
    if (sel == 2'd2) return pc4;
    return alu;
  endfunction

  // Monitor: compares every observed output event against the queued expectations.
  always @(negedge clk) begin
    if (mon_en) begin
      while (wbq.size() > 0 && wbq[0].cyc < cyc) begin
        checks++; failures++;
        $display("FAIL wb_missing: got no writeback, expected rd=%0d data=0x%08h at cycle %0d",
                 wbq[0].addr, wbq[0].data, wbq[0].cyc);
        void'(wbq.pop_front());
      end
      if (rf_writeback_enable === 1'b1) begin
        if (wbq.size() == 0) begin
          checks++; failures++;
          $display("FAIL wb_unexpected: got rd=%0d data=0x%08h, expected no writeback (cycle %0d)",
                   rf_writeback_addr, rf_writeback_data, cyc);
        end else begin
          chk("wb_cycle", cyc, wbq[0].cyc);
          chk("wb_addr", {27'd0, rf_writeback_addr}, {27'd0, wbq[0].addr});
          chk("wb_data", rf_writeback_data, wbq[0].data);
          void'(wbq.pop_front());
        end
      end else begin
        chk("wb_enable_idle", {31'd0, rf_writeback_enable}, 32'd0);
        chk("wb_addr_idle", {27'd0, rf_writeback_addr}, 32'd0);
        chk("wb_data_idle", rf_writeback_data, 32'd0);
      end

      while (errq.size() > 0 && errq[0] < cyc) begin
        checks++; failures++;
        $display("FAIL err_missing: got no mem_error, expected pulse at cycle %0d", errq[0]);
        void'(errq.pop_front());
      end
      if (mem_error === 1'b1) begin
        if (errq.size() == 0) begin
          checks++; failures++;
          $display("FAIL err_unexpected: got mem_error=1, expected 0 (cycle %0d)", cyc);
        end else begin
          chk("err_cycle", cyc, errq[0]);
          void'(errq.pop_front());
        end
      end else begin
        chk("err_idle", {31'd0, mem_error}, 32'd0);
      end

      if (mem_bus.mem_req === 1'b1) begin
        req_cnt++;
        if (!in_req) begin
          if (mq.size() == 0) begin
            checks++; failures++; have_cur = 0;
            $display("FAIL mreq_unexpected: got request addr=0x%08h, expected none", mem_bus.mem_addr);
          end else begin
            cur = mq.pop_front();
            have_cur = 1;
          end
        end
        if (have_cur) begin
          chk("mreq_addr", mem_bus.mem_addr, cur.addr);
          chk("mreq_we", {31'd0, mem_bus.mem_we}, {31'd0, cur.we});
          chk("mreq_wstrb", {28'd0, mem_bus.mem_wstrb}, {28'd0, cur.strb});
          if (cur.we) chk("mreq_wdata", mem_bus.mem_wdata, cur.wdata);
        end
        in_req = 1;
      end else begin
        in_req = 0;
      end
      if (stall === 1'b1) stall_cnt++;
    end
  end

  // Driver: issues one instruction and plays the memory; ends 1 time unit after an edge.
  task automatic do_instr(input bit rd_en, input bit wr_en, input logic [2:0] typ,
                          input logic [31:0] alu, input logic [31:0] pc4, input logic [31:0] sd,
                          input logic [4:0] rd, input bit rfwe, input logic [1:0] sel,
                          input int delay, input logic [31:0] word);
    int unsigned a;
    int unsigned nb;
    int unsigned off;
    bit          done;
    mreq_t       m;
    wb_t         w;
    in_valid = 1'b1; alu_result = alu; pc_plus4 = pc4; dm_write_data = sd;
    rf_write_addr = rd; rf_write_enable = rfwe; rf_write_data_sel = sel;
    dm_read_enable = rd_en; dm_write_enable = wr_en; dm_load_type = typ;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a   = cyc;
    nb  = acc_bytes(typ);
    off = alu % 4;
    if (!rd_en && !wr_en) begin
      if (rfwe && rd != 0) begin
        w.cyc = a + 1; w.addr = rd; w.data = exp_wb(sel, 1'b0, alu, pc4, 32'd0);
        wbq.push_back(w);
      end
      return;
    end
    if (alu % nb != 0) begin
      errq.push_back(a);
      return;
    end
    m.addr  = alu - off;
    m.we    = !rd_en;
    m.strb  = rd_en ? 4'd0 : 4'(((1 << nb) - 1) << off);
    m.wdata = (nb == 1) ? (sd & 32'hFF) * 32'h0101_0101 :
              (nb == 2) ? (sd & 32'hFFFF) * 32'h0001_0001 : sd;
    mq.push_back(m);
    done = 0;
    for (int k = 1; k <= TMO; k++) begin
      in_valid = 1'($urandom); alu_result = $urandom; rf_write_addr = 5'($urandom);
      dm_read_enable = 1'($urandom); dm_write_enable = 1'($urandom);
      rf_write_enable = 1'($urandom); dm_load_type = 3'($urandom); dm_write_data = $urandom;
      mem_bus.mem_ready = (k == delay);
      mem_bus.mem_rdata = (k == delay) ? word : $urandom;
      @(posedge clk); #1;
      mem_bus.mem_ready = 1'b0;
      exp_stall++;
      if (k == delay) begin
        done = 1;
        break;
      end
    end
    in_valid = 1'b0;
    if (done) begin
      if (rfwe && rd != 0) begin
        w.cyc = cyc + 1; w.addr = rd;
        w.data = exp_wb(sel, rd_en, alu, pc4, exp_load(typ, off, word));
        wbq.push_back(w);
      end
    end else begin
      errq.push_back(cyc);
    end
  endtask

  task automatic checkpoint(input string tag);
    in_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk({tag, "_stall_cycles"}, stall_cnt, exp_stall);
    chk({tag, "_req_cycles"}, req_cnt, exp_stall);
    chk({tag, "_wb_pending"}, wbq.size(), 32'd0);
    chk({tag, "_err_pending"}, errq.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected completion within time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          rd_en, wr_en;
    logic [2:0]  typ;
    int          r, delay;
    mem_bus.mem_ready = 1'b0;
    mem_bus.mem_rdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_mem_req", {31'd0, mem_bus.mem_req}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_wb_enable", {31'd0, rf_writeback_enable}, 32'd0);
    chk("rst_wb_addr", {27'd0, rf_writeback_addr}, 32'd0);
    chk("rst_wb_data", rf_writeback_data, 32'd0);
    chk("rst_mem_error", {31'd0, mem_error}, 32'd0);
    chk("rst_mem_addr", mem_bus.mem_addr, 32'd0);
    chk("rst_mem_we", {31'd0, mem_bus.mem_we}, 32'd0);
    chk("rst_mem_wdata", mem_bus.mem_wdata, 32'd0);
    chk("rst_mem_wstrb", {28'd0, mem_bus.mem_wstrb}, 32'd0);
    mon_en = 1;
    @(posedge clk); #1;

    // ADD, LB, LBU, SH, misaligned LW, timed-out LW, ready on the last allowed cycle, JAL to x0
    do_instr(0, 0, 3'd0, 32'h10, 32'h4, 32'h0, 5'd5, 1, 2'd0, 0, 32'h0);
    checkpoint("add");
    do_instr(1, 0, 3'd0, 32'h103, 32'h0, 32'h0, 5'd3, 1, 2'd1, 3, 32'h80AB_CDEF);
    checkpoint("lb");
    do_instr(1, 0, 3'd4, 32'h103, 32'h0, 32'h0, 5'd4, 1, 2'd1, 3, 32'h80AB_CDEF);
    checkpoint("lbu");
    do_instr(0, 1, 3'd1, 32'h202, 32'h0, 32'h1234_5678, 5'd0, 0, 2'd0, 2, 32'h0);
    checkpoint("sh");
    do_instr(1, 0, 3'd2, 32'h006, 32'h0, 32'h0, 5'd6, 1, 2'd1, 1, 32'h0);
    checkpoint("lw_misaligned");
    do_instr(1, 0, 3'd2, 32'h400, 32'h0, 32'h0, 5'd7, 1, 2'd1, 0, 32'h0);
    checkpoint("lw_timeout");
    do_instr(1, 0, 3'd2, 32'h404, 32'h0, 32'h0, 5'd8, 1, 2'd1, TMO, 32'hDEAD_BEEF);
    checkpoint("lw_last_cycle");
    do_instr(0, 0, 3'd0, 32'h99, 32'h44, 32'h0, 5'd0, 1, 2'd2, 0, 32'h0);
    checkpoint("jal_x0");

    // Reset in the middle of an access: request drops and the load never writes back.
    in_valid = 1'b1; alu_result = 32'h300; rf_write_addr = 5'd9; rf_write_enable = 1'b1;
    rf_write_data_sel = 2'd1; dm_read_enable = 1'b1; dm_write_enable = 1'b0; dm_load_type = 3'd2;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cur.addr = 32'h300; cur.we = 1'b0; cur.strb = 4'd0; cur.wdata = 32'h0;
    mq.push_back(cur);
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_stall += 3;
    @(negedge clk);
    chk("rst_access_mem_req", {31'd0, mem_bus.mem_req}, 32'd0);
    chk("rst_access_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    checkpoint("rst_access");

    for (int i = 0; i < 80; i++) begin
      r = int'($urandom_range(0, 3));
      rd_en = (r == 1 || r == 3);
      wr_en = (r == 2 || r == 3);
      typ   = wr_en && !rd_en ? 3'($urandom_range(0, 2)) : load_types[$urandom_range(0, 7)];
      r     = int'($urandom_range(0, 7));
      delay = (r == 0) ? 0 : (r == 1) ? TMO : r - 1;
      do_instr(rd_en, wr_en, typ, $urandom, $urandom, $urandom, 5'($urandom),
               1'($urandom), 2'($urandom), delay, $urandom);
      if ($urandom_range(0, 3) == 0) checkpoint("rand");
    end
    checkpoint("final");
    chk("mreq_pending", mq.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
